transaction_router_n: RTL

//  Parametrised successor of the two-destination transaction layer: one ingress FIFO

---
 rtl/transaction_router_n.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/transaction_router_n.sv
// Ingress FIFO fanning out to NUM_DEST egress FIFOs, steered by the top DEST_W bits of each word,
// with a control FSM that latches occupancy thresholds and traps overflow/underflow.
module transaction_router_n #(
    parameter int DATA_W    = 6,
    parameter int NUM_DEST  = 4,
    parameter int DEST_W    = 2,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         init_i,
    input  logic                         enable_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_in_i,
    input  logic [NUM_DEST-1:0]          pop_i,
    input  logic [CNT_W-1:0]             in_full_umbral_i,
    input  logic [CNT_W-1:0]             out_full_umbral_i,
    input  logic [CNT_W-1:0]             out_empty_umbral_i,
    output logic [NUM_DEST*DATA_W-1:0]   data_out_o,
    output logic [NUM_DEST-1:0]          valid_out_o,
    output logic                         almost_full_in_o,
    output logic [NUM_DEST-1:0]          almost_empty_out_o,
    output logic                         error_out_o,
    output logic                         active_out_o,
    output logic                         idle_out_o,
    output logic [2:0]                   state_out_o
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam logic [CNT_W-1:0] IN_FULL_CNT = CNT_W'(IN_DEPTH);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  inFullThr_q, outFullThr_q, outEmptyThr_q;
    logic [IN_AW-1:0]  inWrPtr_q, inWrPtr_d, inRdPtr_q, inRdPtr_d;
    logic [CNT_W-1:0]  inCount_q, inCount_d;
    logic [OUT_AW-1:0] outWrPtr_q [NUM_DEST];
    logic [OUT_AW-1:0] outWrPtr_d [NUM_DEST];
    logic [OUT_AW-1:0] outRdPtr_q [NUM_DEST];
    logic [OUT_AW-1:0] outRdPtr_d [NUM_DEST];
    logic [CNT_W-1:0]  outCount_q [NUM_DEST];
    logic [CNT_W-1:0]  outCount_d [NUM_DEST];
    logic [DATA_W-1:0] inMem_q [IN_DEPTH];
    logic [DATA_W-1:0] outMem_q [NUM_DEST][OUT_DEPTH];
    logic [NUM_DEST*DATA_W-1:0] dataOut_q, dataOut_d;
    logic [NUM_DEST-1:0]        validOut_q, validOut_d;

    logic              opEn, inEmpty, pushOk, overflow, xfer, errNow, anyData;
    logic [DATA_W-1:0] headWord;
    logic [DEST_W-1:0] headDst;
    logic [NUM_DEST-1:0] outEmpty, popOk, underflowVec, dstHit;

    always_comb begin
        opEn     = enable_i && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
        inEmpty  = (inCount_q == '0);
        headWord = inMem_q[inRdPtr_q];
        headDst  = headWord[DATA_W-1 -: DEST_W];
        // Full is judged on the pre-edge count, so a same-cycle transfer cannot rescue a push.
        pushOk   = opEn && push_i && (inCount_q != IN_FULL_CNT);
        overflow = opEn && push_i && (inCount_q == IN_FULL_CNT);
        xfer     = opEn && !inEmpty && (outCount_q[headDst] < outFullThr_q);
        outEmpty     = '0;
        popOk        = '0;
        underflowVec = '0;
        dstHit       = '0;
        for (int d = 0; d < NUM_DEST; d++) begin
            outEmpty[d]     = (outCount_q[d] == '0);
            popOk[d]        = opEn && pop_i[d] && !outEmpty[d];
            underflowVec[d] = opEn && pop_i[d] && outEmpty[d];
            dstHit[d]       = xfer && (headDst == DEST_W'(d));
        end
        errNow  = overflow || (|underflowVec);
        anyData = !inEmpty || !(&outEmpty);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init_i) state_d = ST_IDLE;
            ST_IDLE: begin
                if (errNow)       state_d = ST_ERROR;
                else if (init_i)  state_d = ST_INIT;
                else if (anyData) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (errNow)        state_d = ST_ERROR;
                else if (!anyData) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        inWrPtr_d  = pushOk ? inWrPtr_q + IN_AW'(1) : inWrPtr_q;
        inRdPtr_d  = xfer ? inRdPtr_q + IN_AW'(1) : inRdPtr_q;
        inCount_d  = inCount_q + {{(CNT_W-1){1'b0}}, pushOk} - {{(CNT_W-1){1'b0}}, xfer};
        dataOut_d  = dataOut_q;
        validOut_d = '0;
        for (int d = 0; d < NUM_DEST; d++) begin
            outWrPtr_d[d] = dstHit[d] ? outWrPtr_q[d] + OUT_AW'(1) : outWrPtr_q[d];
            outRdPtr_d[d] = popOk[d] ? outRdPtr_q[d] + OUT_AW'(1) : outRdPtr_q[d];
            outCount_d[d] = outCount_q[d] + {{(CNT_W-1){1'b0}}, dstHit[d]}
                                          - {{(CNT_W-1){1'b0}}, popOk[d]};
            if (popOk[d]) begin
                dataOut_d[d*DATA_W +: DATA_W] = outMem_q[d][outRdPtr_q[d]];
                validOut_d[d]                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_RESET;
            inFullThr_q   <= CNT_W'(IN_DEPTH - 1);
            outFullThr_q  <= CNT_W'(OUT_DEPTH - 1);
            outEmptyThr_q <= '0;
            inWrPtr_q     <= '0;
            inRdPtr_q     <= '0;
            inCount_q     <= '0;
            dataOut_q     <= '0;
            validOut_q    <= '0;
            for (int d = 0; d < NUM_DEST; d++) begin
                outWrPtr_q[d] <= '0;
                outRdPtr_q[d] <= '0;
                outCount_q[d] <= '0;
            end
        end else begin
            state_q    <= state_d;
            inWrPtr_q  <= inWrPtr_d;
            inRdPtr_q  <= inRdPtr_d;
            inCount_q  <= inCount_d;
            dataOut_q  <= dataOut_d;
            validOut_q <= validOut_d;
            for (int d = 0; d < NUM_DEST; d++) begin
                outWrPtr_q[d] <= outWrPtr_d[d];
                outRdPtr_q[d] <= outRdPtr_d[d];
                outCount_q[d] <= outCount_d[d];
            end
            if ((state_q == ST_INIT) && init_i) begin
                inFullThr_q   <= in_full_umbral_i;
                outFullThr_q  <= out_full_umbral_i;
                outEmptyThr_q <= out_empty_umbral_i;
            end
        end
    end

    // Storage arrays need no reset: pointers and counts alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (pushOk) inMem_q[inWrPtr_q] <= data_in_i;
        for (int d = 0; d < NUM_DEST; d++) begin
            if (dstHit[d]) outMem_q[d][outWrPtr_q[d]] <= headWord;
        end
    end

    always_comb begin
        data_out_o       = dataOut_q;
        valid_out_o      = validOut_q;
        almost_full_in_o = (inCount_q >= inFullThr_q);
        for (int d = 0; d < NUM_DEST; d++) begin
            almost_empty_out_o[d] = (outCount_q[d] <= outEmptyThr_q);
        end
        error_out_o  = (state_q == ST_ERROR);
        active_out_o = (state_q == ST_ACTIVE);
        idle_out_o   = (state_q == ST_IDLE);
        state_out_o  = state_q;
    end

endmodule
